// File: rtl/dense_layer_backprop_elastic_reg.sv
// Elastic `cycle`-stage register carrying the backprop bundle toward the weight-update stage.
// Latency: `cycle` clocks without stalls. Backpressure: in_ready drops only when every stage is full and out_ready=0.
// Optional DENSE_BP_FLUSH_EN adds a `flush` input that empties all stages without touching payload.
module dense_layer_backprop_elastic_reg #(
    parameter int size            = 3,
    parameter int data_size       = 16,
    parameter int cost_type_size  = 8,
    parameter int dense_type_size = 4,
    parameter int cycle           = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
`ifdef DENSE_BP_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [data_size*size-1:0]      grad,
    input  logic [31:0]                    w_layer_index,
    input  logic [31:0]                    w_row_index,
    input  logic                           is_update,
    input  logic [cost_type_size-1:0]      cost_type,
    input  logic [dense_type_size-1:0]     dense_type,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [data_size*size-1:0]      grad_out,
    output logic [31:0]                    w_layer_index_out,
    output logic [31:0]                    w_row_index_out,
    output logic                           is_update_out,
    output logic [cost_type_size-1:0]      cost_type_out,
    output logic [dense_type_size-1:0]     dense_type_out,
    output logic [$clog2(cycle+1)-1:0]     occupancy
);
    localparam int OCC_W = $clog2(cycle + 1);
    localparam int PW    = data_size*size + 32 + 32 + 1 + cost_type_size + dense_type_size;

    logic            flush_i;
    logic [cycle-1:0] v;
    logic [cycle-1:0] adv;
    logic [PW-1:0]   pay [cycle];
    logic [PW-1:0]   in_pay;
    logic            out_go;
    logic            full_above;
    logic            in_fire;
    logic            out_fire;

`ifdef DENSE_BP_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign out_go = out_ready & ~flush_i;

    // A stage advances unless every stage downstream of it is full and the sink is stalled;
    // evaluating that directly avoids a self-referencing combinational chain.
    always_comb begin
        adv        = '0;
        full_above = 1'b1;
        for (int i = 0; i < cycle; i++) begin
            full_above = 1'b1;
            for (int j = i + 1; j < cycle; j++) begin
                full_above = full_above & v[j];
            end
            adv[i] = v[i] & (out_go | ~full_above);
        end
    end

    assign in_ready  = (~v[0] | adv[0]) & ~flush_i;
    assign out_valid = v[cycle-1] & ~flush_i;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign in_pay = {grad, w_layer_index, w_row_index, is_update, cost_type, dense_type};
    assign {grad_out, w_layer_index_out, w_row_index_out,
            is_update_out, cost_type_out, dense_type_out} = pay[cycle-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v         <= '0;
            occupancy <= '0;
            for (int i = 0; i < cycle; i++) begin
                pay[i] <= '0;
            end
        end else if (flush_i) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            if (in_fire) begin
                v[0]   <= 1'b1;
                pay[0] <= in_pay;
            end else begin
                v[0] <= v[0] & ~adv[0];
            end
            for (int i = 1; i < cycle; i++) begin
                if (adv[i-1]) begin
                    v[i]   <= 1'b1;
                    pay[i] <= pay[i-1];
                end else begin
                    v[i] <= v[i] & ~adv[i];
                end
            end
            occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(out_fire);
        end
    end
endmodule

// File: tb/tb_dense_layer_backprop_elastic_reg.sv
// Bench for the elastic backprop register (cycle=3) against a queue-based model of an elastic FIFO pipeline.
module tb_dense_layer_backprop_elastic_reg;
    localparam int CYC = 3;

    typedef struct packed {
        logic [47:0] g;
        logic [31:0] l;
        logic [31:0] r;
        logic        u;
        logic [7:0]  c;
        logic [3:0]  d;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, flush;
    logic [47:0] grad, grad_out;
    logic [31:0] w_layer_index, w_row_index, w_layer_index_out, w_row_index_out;
    logic        is_update, is_update_out;
    logic [7:0]  cost_type, cost_type_out;
    logic [3:0]  dense_type, dense_type_out;
    logic [1:0]  occupancy;

    always #5 clk = ~clk;

    dense_layer_backprop_elastic_reg #(
        .size(3), .data_size(16), .cost_type_size(8), .dense_type_size(4), .cycle(CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef DENSE_BP_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready),
        .grad(grad), .w_layer_index(w_layer_index), .w_row_index(w_row_index),
        .is_update(is_update), .cost_type(cost_type), .dense_type(dense_type),
        .out_valid(out_valid), .out_ready(out_ready),
        .grad_out(grad_out), .w_layer_index_out(w_layer_index_out),
        .w_row_index_out(w_row_index_out), .is_update_out(is_update_out),
        .cost_type_out(cost_type_out), .dense_type_out(dense_type_out),
        .occupancy(occupancy)
    );

    bundle_t q[$];
    int      tq[$];
    int      dut_rows[$];
    int      edge_n = 0;
    int      checks = 0;
    int      errors = 0;
    int      occ_peak = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t cur_out();
        return {grad_out, w_layer_index_out, w_row_index_out, is_update_out, cost_type_out, dense_type_out};
    endfunction

    task automatic set_bundle(input int row);
        grad          = 48'({$urandom(), $urandom()});
        w_layer_index = $urandom();
        w_row_index   = row;
        is_update     = 1'($urandom());
        cost_type     = 8'($urandom());
        dense_type    = 4'($urandom());
    endtask

    // One clock: check DUT against the model, then advance the model across the edge.
    // acc reports whether the DUT itself showed in_valid & in_ready.
    task automatic step(input bit do_chk, output bit acc);
        bit      er, ev, inf, outf;
        bundle_t b;
        #1;
        er = ((q.size() < CYC) || out_ready) && !flush;
        ev = (q.size() > 0) && ((edge_n - tq[0]) >= CYC - 1) && !flush;
        if (do_chk && rst_n) begin
            chk("in_ready", 128'(in_ready), 128'(er));
            chk("out_valid", 128'(out_valid), 128'(ev));
            chk("occupancy", 128'(occupancy), 128'(q.size()));
            if (ev) chk("payload", 128'(cur_out()), 128'(q[0]));
        end
        if (int'(occupancy) > occ_peak) occ_peak = int'(occupancy);
        if (rst_n && out_valid && out_ready) dut_rows.push_back(int'(w_row_index_out));
        acc  = rst_n && in_valid && in_ready;
        inf  = rst_n && in_valid && er;
        outf = rst_n && ev && out_ready;
        b    = {grad, w_layer_index, w_row_index, is_update, cost_type, dense_type};
        @(posedge clk);
        edge_n++;
        if (!rst_n || flush) begin
            q.delete();
            tq.delete();
        end else begin
            if (outf) begin
                void'(q.pop_front());
                void'(tq.pop_front());
            end
            if (inf) begin
                q.push_back(b);
                tq.push_back(edge_n);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int n, nacc;
        bit hold;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        set_bundle(99);
        @(negedge clk);

        // Reset with in_valid held high.
        step(0, acc);
        step(0, acc);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_payload", 128'(cur_out()), 128'(0));
        rst_n = 1'b1; in_valid = 1'b0;
        step(1, acc);
        step(1, acc);

        // Single-bundle latency.
        out_ready = 1'b1; in_valid = 1'b1;
        grad = 48'h0003_0002_0001; w_layer_index = 0; w_row_index = 7;
        is_update = 1'b1; cost_type = 0; dense_type = 0;
        step(1, acc);
        chk("lat_accept", 128'(acc), 128'(1));
        in_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (out_valid) break;
            n++;
            step(1, acc);
        end
        chk("latency", 128'(n), 128'(CYC - 1));
        chk("lat_grad", 128'(grad_out), 128'(48'h0003_0002_0001));
        chk("lat_row", 128'(w_row_index_out), 128'(7));
        chk("lat_upd", 128'(is_update_out), 128'(1));
        for (int k = 0; k < 3; k++) step(1, acc);

        // Back-to-back streaming.
        dut_rows.delete();
        occ_peak = 0;
        in_valid = 1'b1;
        for (int r = 0; r < 10; r++) begin
            set_bundle(r);
            step(1, acc);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step(1, acc);
        chk("stream_count", 128'(dut_rows.size()), 128'(10));
        for (int r = 0; r < 10 && r < dut_rows.size(); r++) chk("stream_order", 128'(dut_rows[r]), 128'(r));
        chk("stream_peak", 128'(occ_peak), 128'(CYC));

        // Backpressure: five attempts with the sink stalled.
        dut_rows.delete();
        out_ready = 1'b0; in_valid = 1'b1; nacc = 0;
        set_bundle(100);
        for (int k = 0; k < 5; k++) begin
            step(1, acc);
            if (acc) begin
                nacc++;
                set_bundle(100 + nacc);
            end
        end
        chk("bp_accepted", 128'(nacc), 128'(3));
        chk("bp_hold_row", 128'(w_row_index_out), 128'(100));
        out_ready = 1'b1;
        step(1, acc);
        chk("bp_swap_accept", 128'(acc), 128'(1));
        chk("bp_swap_out", 128'(dut_rows.size() > 0 ? dut_rows[0] : -1), 128'(100));
        out_ready = 1'b0; in_valid = 1'b0;
        step(1, acc);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step(1, acc);

        // Reset with two bundles in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        set_bundle(200); step(1, acc);
        set_bundle(201); step(1, acc);
        in_valid = 1'b0;
        step(1, acc);
        chk("mid_occ_before", 128'(occupancy), 128'(2));
        rst_n = 1'b0;
        step(0, acc);
        rst_n = 1'b1;
        #1;
        chk("mid_occ_after", 128'(occupancy), 128'(0));
        chk("mid_valid_after", 128'(out_valid), 128'(0));
        out_ready = 1'b1; in_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            set_bundle(300 + r);
            step(1, acc);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step(1, acc);

        // Random traffic; a stalled bundle is held until accepted.
        hold = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 1));
                set_bundle(int'($urandom_range(0, 65535)));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step(1, acc);
            hold = in_valid && !acc;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step(1, acc);

`ifdef DENSE_BP_FLUSH_EN
        out_ready = 1'b0; in_valid = 1'b1;
        for (int r = 0; r < 3; r++) begin
            set_bundle(400 + r);
            step(1, acc);
        end
        #1;
        chk("flush_occ_before", 128'(occupancy), 128'(3));
        flush = 1'b1; out_ready = 1'b1;
        step(1, acc);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_occ_after", 128'(occupancy), 128'(0));
        chk("flush_valid_after", 128'(out_valid), 128'(0));
        chk("flush_ready_after", 128'(in_ready), 128'(1));
        step(1, acc);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
